// File: rtl/seq_detect_prog.sv
// seq_detect_prog: runtime-programmable serial pattern detector.
// Compares a qualified serial bit stream against a loadable PAT_W-bit pattern
// and emits a registered one-cycle match pulse. Overlap mode is selectable.
// Optional feature macro: SEQDET_COUNT_EN adds a saturating match counter
// (match_count / count_sat); without it those outputs are tied to 0.
module seq_detect_prog #(
    parameter int unsigned          PAT_W     = 4,
    parameter logic [PAT_W-1:0]     RESET_PAT = PAT_W'(4'b1011),
    parameter int unsigned          CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap_en,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             count_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  pat, pat_nxt;
    logic [PAT_W-1:0]  win, win_nxt;
    logic [FILL_W-1:0] fill, fill_nxt;
    logic              match_nxt;

    logic [PAT_W-1:0]  win_shift;
    logic [FILL_W-1:0] fill_inc;
    logic              hit_c;

    // Next-state for pattern, history window, fill count and match pulse
    always_comb begin
        win_shift = {win[PAT_W-2:0], bit_in};
        fill_inc  = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
        hit_c     = bit_valid && !pat_load && (fill_inc == FILL_FULL) && (win_shift == pat);

        pat_nxt   = pat;
        win_nxt   = win;
        fill_nxt  = fill;
        match_nxt = 1'b0;

        if (pat_load) begin
            // Loading discards the history and any bit presented this edge
            pat_nxt  = pat_in;
            win_nxt  = '0;
            fill_nxt = '0;
        end else if (bit_valid) begin
            win_nxt   = win_shift;
            fill_nxt  = (hit_c && !overlap_en) ? '0 : fill_inc;
            match_nxt = hit_c;
        end
    end

    // Detector state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pat   <= RESET_PAT;
            win   <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else begin
            pat   <= pat_nxt;
            win   <= win_nxt;
            fill  <= fill_nxt;
            match <= match_nxt;
        end
    end

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sat, sat_nxt;

    // Saturating counter next-state; clear beats a coincident hit
    always_comb begin
        cnt_nxt = cnt;
        sat_nxt = sat;
        if (count_clr) begin
            cnt_nxt = '0;
            sat_nxt = 1'b0;
        end else if (hit_c) begin
            if (&cnt) begin
                sat_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // Counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            sat <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            sat <= sat_nxt;
        end
    end

    assign match_count = cnt;
    assign count_sat   = sat;
`else
    logic unused_count_clr;

    assign unused_count_clr = count_clr;
    assign match_count      = '0;
    assign count_sat        = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Testbench for seq_detect_prog: directed vectors with hand-computed
// expectations pushed into a scoreboard queue and checked by a monitor.
// Two instances: PAT_W=4/CNT_W=2 (default pattern 1011) and PAT_W=8.
module tb_seq_detect_prog;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: PAT_W=4, RESET_PAT=1011, CNT_W=2
    logic       a_rst = 1'b1, a_pat_load = 1'b0, a_overlap_en = 1'b1;
    logic       a_bit_valid = 1'b0, a_bit_in = 1'b0, a_count_clr = 1'b0;
    logic [3:0] a_pat_in = 4'd0;
    logic       a_match, a_count_sat;
    logic [1:0] a_match_count;

    // Instance B: PAT_W=8, RESET_PAT=0, CNT_W=8
    logic       b_rst = 1'b1, b_pat_load = 1'b0, b_overlap_en = 1'b1;
    logic       b_bit_valid = 1'b0, b_bit_in = 1'b0, b_count_clr = 1'b0;
    logic [7:0] b_pat_in = 8'd0;
    logic       b_match, b_count_sat;
    logic [7:0] b_match_count;

    seq_detect_prog #(.PAT_W(4), .RESET_PAT(4'b1011), .CNT_W(2)) dut_a (
        .clk(clk), .rst(a_rst), .pat_load(a_pat_load), .pat_in(a_pat_in),
        .overlap_en(a_overlap_en), .bit_valid(a_bit_valid), .bit_in(a_bit_in),
        .count_clr(a_count_clr), .match(a_match), .match_count(a_match_count),
        .count_sat(a_count_sat)
    );

    seq_detect_prog #(.PAT_W(8), .RESET_PAT(8'h00), .CNT_W(8)) dut_b (
        .clk(clk), .rst(b_rst), .pat_load(b_pat_load), .pat_in(b_pat_in),
        .overlap_en(b_overlap_en), .bit_valid(b_bit_valid), .bit_in(b_bit_in),
        .count_clr(b_count_clr), .match(b_match), .match_count(b_match_count),
        .count_sat(b_count_sat)
    );

    typedef struct {
        bit    sel;
        bit    m;
        int    cnt;
        bit    sat;
        string name;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Stream 1,0,1,1,0,1,1 and expected pulses / counts
    bit t1b [7] = '{1, 0, 1, 1, 0, 1, 1};
    bit t1m [7] = '{0, 0, 0, 1, 0, 0, 1};
    int t1c [7] = '{0, 0, 0, 1, 1, 1, 2};
    bit t2m [7] = '{0, 0, 0, 1, 0, 0, 0};
    int t2c [7] = '{0, 0, 0, 1, 1, 1, 1};
    // Pattern A5 stream for instance B
    bit t4b [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    // Stream after a reload: one bit short of A5
    bit t4r [7] = '{0, 1, 0, 0, 1, 0, 1};

    // Drive one cycle of inputs on the selected instance and queue its expected outputs
    task automatic step(input bit sel, input bit r, input bit ld, input logic [7:0] pin,
                        input bit ov, input bit bv, input bit bi, input bit clr,
                        input bit em, input int ecnt, input bit esat, input string nm);
        exp_t e;
        @(negedge clk);
        a_rst = 1'b0; a_pat_load = 1'b0; a_bit_valid = 1'b0; a_count_clr = 1'b0;
        b_rst = 1'b0; b_pat_load = 1'b0; b_bit_valid = 1'b0; b_count_clr = 1'b0;
        if (!sel) begin
            a_rst = r; a_pat_load = ld; a_pat_in = pin[3:0]; a_overlap_en = ov;
            a_bit_valid = bv; a_bit_in = bi; a_count_clr = clr;
        end else begin
            b_rst = r; b_pat_load = ld; b_pat_in = pin; b_overlap_en = ov;
            b_bit_valid = bv; b_bit_in = bi; b_count_clr = clr;
        end
        e.sel = sel; e.m = em; e.cnt = ecnt; e.sat = esat; e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic bit_a(input bit ov, input bit bi, input bit em, input int ec,
                         input bit es, input string nm);
        step(1'b0, 1'b0, 1'b0, 8'd0, ov, 1'b1, bi, 1'b0, em, ec, es, nm);
    endtask

    task automatic gap_a(input int ec, input string nm);
        step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ec, 1'b0, nm);
    endtask

    task automatic rst_a();
        step(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, "a_reset");
    endtask

    task automatic bit_b(input bit bi, input bit em, input int ec, input string nm);
        step(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, bi, 1'b0, em, ec, 1'b0, nm);
    endtask

    // Monitor: one cycle after each active edge, pop and compare
    initial begin
        exp_t e;
        int   act_cnt, exp_cnt;
        bit   act_m, act_sat, exp_sat;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                act_m   = e.sel ? b_match : a_match;
                act_cnt = e.sel ? int'(b_match_count) : int'(a_match_count);
                act_sat = e.sel ? b_count_sat : a_count_sat;
`ifdef SEQDET_COUNT_EN
                exp_cnt = e.cnt;
                exp_sat = e.sat;
`else
                exp_cnt = 0;
                exp_sat = 1'b0;
`endif
                n_tests++;
                if (act_m !== e.m) begin
                    n_fail++;
                    $display("FAIL %s.match got %0d want %0d", e.name, act_m, e.m);
                end
                n_tests++;
                if (act_cnt != exp_cnt) begin
                    n_fail++;
                    $display("FAIL %s.match_count got %0d want %0d", e.name, act_cnt, exp_cnt);
                end
                n_tests++;
                if (act_sat !== exp_sat) begin
                    n_fail++;
                    $display("FAIL %s.count_sat got %0d want %0d", e.name, act_sat, exp_sat);
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [3:0] p1011;
        int         hits;
        p1011 = 4'b1011;

        // Reset state on both instances
        rst_a();
        step(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, "b_reset");

        // Overlapping: hits after bits 4 and 7
        for (int i = 0; i < 7; i++) bit_a(1'b1, t1b[i], t1m[i], t1c[i], 1'b0, "ovl_on");
        step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, "clr_idle");

        // Non-overlapping: only the first hit
        rst_a();
        for (int i = 0; i < 7; i++) bit_a(1'b0, t1b[i], t2m[i], t2c[i], 1'b0, "ovl_off");

        // Gapped stream: three idle cycles between every bit
        rst_a();
        for (int i = 0; i < 4; i++) begin
            bit_a(1'b1, t1b[i], i == 3, (i == 3) ? 1 : 0, 1'b0, "gap_bit");
            for (int g = 0; g < 3; g++) gap_a((i == 3) ? 1 : 0, "gap_idle");
        end

        // Counter saturation with CNT_W=2; clear coincides with the 5th hit
        rst_a();
        for (int i = 0; i < 20; i++) begin
            hits = (i + 1) / 4;
            if (i == 19) begin
                step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, p1011[3 - (i % 4)], 1'b1,
                     1'b1, 0, 1'b0, "sat_clr_hit");
            end else begin
                bit_a(1'b1, p1011[3 - (i % 4)], (i % 4) == 3, (hits > 3) ? 3 : hits,
                      hits > 3, "sat_run");
            end
        end

        // Reset mid-sequence discards history; reset wins over a valid bit
        rst_a();
        bit_a(1'b1, 1'b1, 1'b0, 0, 1'b0, "pre_rst");
        bit_a(1'b1, 1'b0, 1'b0, 0, 1'b0, "pre_rst");
        bit_a(1'b1, 1'b1, 1'b0, 0, 1'b0, "pre_rst");
        step(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, "mid_rst");
        bit_a(1'b1, 1'b1, 1'b0, 0, 1'b0, "post_rst1");
        bit_a(1'b1, 1'b0, 1'b0, 0, 1'b0, "post_rst2");
        bit_a(1'b1, 1'b1, 1'b0, 0, 1'b0, "post_rst3");
        bit_a(1'b1, 1'b1, 1'b1, 1, 1'b0, "post_rst4");

        // PAT_W=8: load A5 with a coincident valid bit that must be discarded
        step(1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, "b_load");
        for (int i = 0; i < 8; i++) bit_b(t4b[i], i == 7, (i == 7) ? 1 : 0, "b_a5");
        // Reload: the load-cycle bit would complete A5 if it were kept
        step(1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0, "b_reload");
        for (int i = 0; i < 7; i++) bit_b(t4r[i], 1'b0, 1, "b_discard");

        // Drain the scoreboard with a bounded wait
        step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, "idle_end");
        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
        #3;
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending want 0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
